// File: rtl/jt6295_serial_multi.sv
// Time-multiplexed ADPCM voice sequencer: CH voices share one ROM port, one slot per cen4,
// and produce a serial nibble stream tagged with channel and attenuation.
module jt6295_serial_multi #(
    parameter int unsigned CH   = 4,
    parameter int unsigned AW   = 18,
    parameter int unsigned ATTW = 4,
    localparam int unsigned CW  = $clog2(CH)
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen,
    input  logic            cen4,
    input  logic [AW-1:0]   start_addr,
    input  logic [AW-1:0]   stop_addr,
    input  logic [ATTW-1:0] att,
    input  logic            loop,
    input  logic [CH-1:0]   start,
    input  logic [CH-1:0]   stop,
    output logic [CH-1:0]   busy,
    output logic [AW-1:0]   rom_addr,
    input  logic [7:0]      rom_data,
    output logic            pipe_en,
    output logic [ATTW-1:0] pipe_att,
    output logic [3:0]      pipe_data,
    output logic [CW-1:0]   pipe_ch
);

    logic [CW-1:0]   slot_q, slot_d;
    logic [CH-1:0]   start_l_q, start_l_d;
    logic [CH-1:0]   stop_l_q, stop_l_d;
    logic [CH-1:0]   busy_q, busy_d;
    logic [CH-1:0]   lp_q, lp_d;
    logic [AW:0]     cnt_q [CH];
    logic [AW:0]     cnt_d [CH];
    logic [AW-1:0]   end_q [CH];
    logic [AW-1:0]   end_d [CH];
    logic [AW-1:0]   ld_q [CH];
    logic [AW-1:0]   ld_d [CH];
    logic [ATTW-1:0] att_q [CH];
    logic [ATTW-1:0] att_d [CH];

    logic            s1_sel_q, s1_sel_d;
    logic            s1_en_q, s1_en_d;
    logic [ATTW-1:0] s1_att_q, s1_att_d;
    logic [CW-1:0]   s1_ch_q, s1_ch_d;

    logic            pipe_en_q, pipe_en_d;
    logic [ATTW-1:0] pipe_att_q, pipe_att_d;
    logic [3:0]      pipe_data_q, pipe_data_d;
    logic [CW-1:0]   pipe_ch_q, pipe_ch_d;

    logic [AW:0]     cur_cnt;
    logic            cur_over;
    logic            cur_en;

    assign cur_cnt  = cnt_q[slot_q];
    assign cur_over = cur_cnt[AW:1] >= end_q[slot_q];
    // All terms use pre-update state, so the stop nibble and the loop-wrap slot stay silent.
    assign cur_en   = busy_q[slot_q] & ~start_l_q[slot_q] & ~stop_l_q[slot_q] & ~cur_over;

    always_comb begin
        slot_d      = slot_q;
        start_l_d   = start_l_q;
        stop_l_d    = stop_l_q;
        busy_d      = busy_q;
        lp_d        = lp_q;
        cnt_d       = cnt_q;
        end_d       = end_q;
        ld_d        = ld_q;
        att_d       = att_q;
        s1_sel_d    = s1_sel_q;
        s1_en_d     = s1_en_q;
        s1_att_d    = s1_att_q;
        s1_ch_d     = s1_ch_q;
        pipe_en_d   = pipe_en_q;
        pipe_att_d  = pipe_att_q;
        pipe_data_d = pipe_data_q;
        pipe_ch_d   = pipe_ch_q;

        if (cen4) begin
            slot_d = (slot_q == CW'(CH - 1)) ? '0 : slot_q + CW'(1);
            start_l_d[slot_q] = 1'b0;
            stop_l_d[slot_q]  = 1'b0;

            if (start_l_q[slot_q]) begin
                cnt_d[slot_q]  = {start_addr, 1'b0};
                end_d[slot_q]  = stop_addr;
                ld_d[slot_q]   = start_addr;
                att_d[slot_q]  = att;
                lp_d[slot_q]   = loop;
                busy_d[slot_q] = 1'b1;
            end else if (stop_l_q[slot_q]) begin
                busy_d[slot_q] = 1'b0;
            end else if (busy_q[slot_q]) begin
                if (cur_over) begin
                    if (lp_q[slot_q]) begin
                        cnt_d[slot_q] = {ld_q[slot_q], 1'b0};
                    end else begin
                        busy_d[slot_q] = 1'b0;
                    end
                end else begin
                    cnt_d[slot_q] = cur_cnt + 1'b1;
                end
            end

            s1_sel_d = cur_cnt[0];
            s1_en_d  = cur_en;
            s1_att_d = att_q[slot_q];
            s1_ch_d  = slot_q;

            pipe_en_d   = s1_en_q;
            pipe_att_d  = s1_att_q;
            pipe_ch_d   = s1_ch_q;
            pipe_data_d = s1_sel_q ? rom_data[3:0] : rom_data[7:4];
        end

        // Set after clear: a request arriving on its own service slot waits for the next pass.
        if (cen) begin
            start_l_d = start_l_d | start;
            stop_l_d  = stop_l_d | stop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            start_l_q   <= '0;
            stop_l_q    <= '0;
            busy_q      <= '0;
            lp_q        <= '0;
            s1_sel_q    <= 1'b0;
            s1_en_q     <= 1'b0;
            s1_att_q    <= '0;
            s1_ch_q     <= '0;
            pipe_en_q   <= 1'b0;
            pipe_att_q  <= '0;
            pipe_data_q <= '0;
            pipe_ch_q   <= '0;
            for (int i = 0; i < int'(CH); i++) begin
                cnt_q[i] <= '0;
                end_q[i] <= '0;
                ld_q[i]  <= '0;
                att_q[i] <= '0;
            end
        end else begin
            slot_q      <= slot_d;
            start_l_q   <= start_l_d;
            stop_l_q    <= stop_l_d;
            busy_q      <= busy_d;
            lp_q        <= lp_d;
            s1_sel_q    <= s1_sel_d;
            s1_en_q     <= s1_en_d;
            s1_att_q    <= s1_att_d;
            s1_ch_q     <= s1_ch_d;
            pipe_en_q   <= pipe_en_d;
            pipe_att_q  <= pipe_att_d;
            pipe_data_q <= pipe_data_d;
            pipe_ch_q   <= pipe_ch_d;
            for (int i = 0; i < int'(CH); i++) begin
                cnt_q[i] <= cnt_d[i];
                end_q[i] <= end_d[i];
                ld_q[i]  <= ld_d[i];
                att_q[i] <= att_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign rom_addr  = cur_cnt[AW:1];
    assign pipe_en   = pipe_en_q;
    assign pipe_att  = pipe_att_q;
    assign pipe_data = pipe_data_q;
    assign pipe_ch   = pipe_ch_q;

endmodule

// File: tb/tb_jt6295_serial_multi.sv
// Bench for jt6295_serial_multi: a 4-channel and an 8-channel instance share one clock and
// reset; nibble streams are predicted from addresses, lengths and slot timing.
module tb_jt6295_serial_multi;

    typedef struct packed {
        int t;
        int ch;
        int data;
        int att;
    } ev_t;

    logic clk = 1'b0, rst = 1'b1, cen4 = 1'b0, cen_a = 1'b0, cen_b = 1'b0;
    int   div = 0, k4 = 0, mk = 0;
    int   n_chk = 0, n_fail = 0;

    logic [17:0] start_addr_a = '0, stop_addr_a = '0, rom_addr_a;
    logic [3:0]  att_a = '0, start_a = '0, stop_a = '0, busy_a, pipe_att_a, pipe_data_a;
    logic        loop_a = 1'b0, pipe_en_a;
    logic [7:0]  rom_data_a = '0;
    logic [1:0]  pipe_ch_a;

    logic [19:0] start_addr_b = '0, stop_addr_b = '0, rom_addr_b;
    logic [3:0]  att_b = '0, pipe_att_b, pipe_data_b;
    logic [7:0]  start_b = '0, stop_b = '0, busy_b;
    logic        loop_b = 1'b0, pipe_en_b;
    logic [7:0]  rom_data_b = '0;
    logic [2:0]  pipe_ch_b;

    logic [7:0]  rom_mem [0:4095];
    logic [3:0]  bh_a [0:4095];
    logic [7:0]  bh_b [0:4095];
    ev_t         qa[$], qb[$], exp_q[$], got_q[$];
    ev_t         mon_e;

    jt6295_serial_multi #(.CH(4), .AW(18), .ATTW(4)) u_dut_a (
        .rst(rst), .clk(clk), .cen(cen_a), .cen4(cen4),
        .start_addr(start_addr_a), .stop_addr(stop_addr_a), .att(att_a), .loop(loop_a),
        .start(start_a), .stop(stop_a), .busy(busy_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .pipe_en(pipe_en_a), .pipe_att(pipe_att_a),
        .pipe_data(pipe_data_a), .pipe_ch(pipe_ch_a)
    );

    jt6295_serial_multi #(.CH(8), .AW(20), .ATTW(4)) u_dut_b (
        .rst(rst), .clk(clk), .cen(cen_b), .cen4(cen4),
        .start_addr(start_addr_b), .stop_addr(stop_addr_b), .att(att_b), .loop(loop_b),
        .start(start_b), .stop(stop_b), .busy(busy_b), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .pipe_en(pipe_en_b), .pipe_att(pipe_att_b),
        .pipe_data(pipe_data_b), .pipe_ch(pipe_ch_b)
    );

    always #5 clk = ~clk;

    // k4 is the index of the next cen4 edge since reset release.
    always @(negedge clk) begin
        div   = (div + 1) % 4;
        cen4  = (div == 3);
        cen_a = cen4 && (k4 % 4 == 0);
        cen_b = cen4 && (k4 % 8 == 0);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) k4 <= 0;
        else if (cen4) k4 <= k4 + 1;
    end

    // ROM answers one cen4 after the address is presented.
    always @(posedge clk) begin
        if (cen4) begin
            rom_data_a <= rom_mem[rom_addr_a[11:0]];
            rom_data_b <= rom_mem[rom_addr_b[11:0]];
        end
    end

    always @(posedge clk) begin
        if (cen4 && !rst) begin
            mk = k4;
            #1;
            if (pipe_en_a) begin
                mon_e.t = mk; mon_e.ch = int'(pipe_ch_a);
                mon_e.data = int'(pipe_data_a); mon_e.att = int'(pipe_att_a);
                qa.push_back(mon_e);
            end
            if (pipe_en_b) begin
                mon_e.t = mk; mon_e.ch = int'(pipe_ch_b);
                mon_e.data = int'(pipe_data_b); mon_e.att = int'(pipe_att_b);
                qb.push_back(mon_e);
            end
            if (mk < 4096) begin
                bh_a[mk] = busy_a;
                bh_b[mk] = busy_b;
            end
        end
    end

    function automatic int first_k(input int t, input int n, input int ch);
        return t + ((n - t % ch - 1 + 2 * ch) % ch) + 1;
    endfunction

    // Slot n plays nibble m of its sample on its (m+1)-th pass after the start pass, with the
    // result appearing one cen4 later; a looping sample adds one silent pass per wrap.
    task automatic model_stream(input int n, input int k1, input int kend, input int st,
                                input int len, input int lp, input int at, input int ch);
        int p, m;
        logic [7:0] b;
        ev_t e;
        for (int t = k1 + ch + 1; t < kend; t += ch) begin
            p = (t - 1 - k1) / ch;
            m = lp != 0 ? (p - 1) % (2 * len + 1) : p - 1;
            if (lp == 0 && m >= 2 * len) break;
            if (m < 2 * len) begin
                b = rom_mem[(st + m / 2) & 4095];
                e.t = t; e.ch = n; e.att = at;
                e.data = (m % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic collect(input bit use_b, input int n);
        got_q.delete();
        if (!use_b) begin
            foreach (qa[i]) if (qa[i].ch == n) got_q.push_back(qa[i]);
        end else begin
            foreach (qb[i]) if (qb[i].ch == n) got_q.push_back(qb[i]);
        end
    endtask

    task automatic next_cen4();
        do @(posedge clk); while (!cen4);
        #2;
    endtask

    task automatic wait_k(input int k);
        while (k4 <= k) @(posedge clk);
        #2;
    endtask

    task automatic req_a(input logic [3:0] s, input logic [3:0] p, output int t);
        start_a = s; stop_a = p; t = -1;
        for (int i = 0; i < 64 && t < 0; i++) begin
            @(posedge clk);
            if (cen_a) t = k4;
        end
        #2;
        start_a = '0; stop_a = '0;
    endtask

    task automatic req_b(input logic [7:0] s, input logic [7:0] p, output int t);
        start_b = s; stop_b = p; t = -1;
        for (int i = 0; i < 128 && t < 0; i++) begin
            @(posedge clk);
            if (cen_b) t = k4;
        end
        #2;
        start_b = '0; stop_b = '0;
    endtask

    task automatic set_a(input int st, input int len, input int at, input bit lp);
        start_addr_a = 18'(st); stop_addr_a = 18'(st + len); att_a = 4'(at); loop_a = lp;
    endtask

    task automatic test_reset();
        repeat (10) @(posedge clk);
        #2;
        n_chk += 12;
        if (busy_a !== '0)      begin n_fail++; $display("FAIL rst_busy_a: got %0h want 0", busy_a); end
        if (pipe_en_a !== 1'b0) begin n_fail++; $display("FAIL rst_en_a: got %0h want 0", pipe_en_a); end
        if (pipe_data_a !== '0) begin n_fail++; $display("FAIL rst_data_a: got %0h want 0", pipe_data_a); end
        if (pipe_att_a !== '0)  begin n_fail++; $display("FAIL rst_att_a: got %0h want 0", pipe_att_a); end
        if (pipe_ch_a !== '0)   begin n_fail++; $display("FAIL rst_ch_a: got %0h want 0", pipe_ch_a); end
        if (rom_addr_a !== '0)  begin n_fail++; $display("FAIL rst_addr_a: got %0h want 0", rom_addr_a); end
        if (busy_b !== '0)      begin n_fail++; $display("FAIL rst_busy_b: got %0h want 0", busy_b); end
        if (pipe_en_b !== 1'b0) begin n_fail++; $display("FAIL rst_en_b: got %0h want 0", pipe_en_b); end
        if (pipe_data_b !== '0) begin n_fail++; $display("FAIL rst_data_b: got %0h want 0", pipe_data_b); end
        if (pipe_att_b !== '0)  begin n_fail++; $display("FAIL rst_att_b: got %0h want 0", pipe_att_b); end
        if (pipe_ch_b !== '0)   begin n_fail++; $display("FAIL rst_ch_b: got %0h want 0", pipe_ch_b); end
        if (rom_addr_b !== '0)  begin n_fail++; $display("FAIL rst_addr_b: got %0h want 0", rom_addr_b); end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) next_cen4();
        n_chk++;
        if (qa.size() != 0 || busy_a !== '0) begin
            n_fail++; $display("FAIL idle_a: got %0d events busy %0h want 0", qa.size(), busy_a);
        end
    endtask

    task automatic test_oneshot();
        int n, st, len, at, t, k1;
        for (int run = 0; run < 2; run++) begin
            n   = run == 0 ? 1 : int'($urandom_range(0, 3));
            st  = run == 0 ? 'h100 : int'($urandom_range(0, 'hF00));
            len = run == 0 ? 2 : int'($urandom_range(1, 4));
            at  = int'($urandom_range(0, 15));
            set_a(st, len, at, 1'b0);
            qa.delete();
            req_a(4'(1 << n), 4'h0, t);
            k1 = first_k(t, n, 4);
            wait_k(k1 + (2 * len + 1) * 4 + 4);
            exp_q.delete();
            model_stream(n, k1, k4, st, len, 0, at, 4);
            collect(1'b0, n);
            n_chk++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL oneshot_len: got %0d want %0d", got_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_chk++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL oneshot_nib%0d: got t%0d d%0h a%0h want t%0d d%0h a%0h", i,
                             got_q[i].t, got_q[i].data, got_q[i].att,
                             exp_q[i].t, exp_q[i].data, exp_q[i].att);
                end
            end
            n_chk += 3;
            if (bh_a[k1 - 1][n] !== 1'b0) begin n_fail++; $display("FAIL oneshot_pre: got 1 want 0"); end
            if (bh_a[k1 + 8 * len][n] !== 1'b1) begin n_fail++; $display("FAIL oneshot_busy: got 0 want 1"); end
            if (bh_a[k1 + 8 * len + 4][n] !== 1'b0) begin
                n_fail++; $display("FAIL oneshot_done: got 1 want 0");
            end
        end
    endtask

    task automatic test_loop();
        int n, st, len, at, t, k1, t2, k2;
        n = 1; st = int'($urandom_range(0, 'hF00)); len = int'($urandom_range(1, 3));
        at = int'($urandom_range(0, 15));
        set_a(st, len, at, 1'b1);
        qa.delete();
        req_a(4'b0010, 4'h0, t);
        k1 = first_k(t, n, 4);
        wait_k(k1 + 3 * (2 * len + 1) * 4 + 2);
        req_a(4'h0, 4'b0010, t2);
        k2 = first_k(t2, n, 4);
        wait_k(k2 + 12);
        exp_q.delete();
        model_stream(n, k1, k2 + 1, st, len, 1, at, 4);
        collect(1'b0, n);
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL loop_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL loop_nib%0d: got t%0d d%0h want t%0d d%0h", i,
                         got_q[i].t, got_q[i].data, exp_q[i].t, exp_q[i].data);
            end
        end
        n_chk += 3;
        if (bh_a[k1 + (2 * len + 1) * 4][n] !== 1'b1) begin n_fail++; $display("FAIL loop_wrap_busy: got 0 want 1"); end
        if (bh_a[k2 - 1][n] !== 1'b1) begin n_fail++; $display("FAIL loop_prestop: got 0 want 1"); end
        if (bh_a[k2][n] !== 1'b0) begin n_fail++; $display("FAIL loop_stop: got 1 want 0"); end
    endtask

    task automatic test_stop();
        int n, st, len, at, t, k1, t2, k2;
        n = 2; st = int'($urandom_range(0, 'hF00)); len = int'($urandom_range(4, 8));
        at = int'($urandom_range(0, 15));
        set_a(st, len, at, 1'b0);
        qa.delete();
        req_a(4'b0100, 4'h0, t);
        k1 = first_k(t, n, 4);
        wait_k(k1 + 4 * int'($urandom_range(2, len)));
        req_a(4'h0, 4'b0100, t2);
        k2 = first_k(t2, n, 4);
        wait_k(k2 + 16);
        exp_q.delete();
        model_stream(n, k1, k2 + 1, st, len, 0, at, 4);
        collect(1'b0, n);
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stop_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stop_nib%0d: got t%0d d%0h want t%0d d%0h", i,
                         got_q[i].t, got_q[i].data, exp_q[i].t, exp_q[i].data);
            end
        end
        n_chk += 2;
        if (bh_a[k2 - 1][n] !== 1'b1) begin n_fail++; $display("FAIL stop_pre: got 0 want 1"); end
        if (bh_a[k2][n] !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got 1 want 0"); end
    endtask

    task automatic test_restart();
        int sa, sb, lb, ata, atb, t, k1, t2, k2;
        sa = int'($urandom_range(0, 'h7FF)); sb = int'($urandom_range('h800, 'hF00));
        lb = int'($urandom_range(1, 3));
        ata = int'($urandom_range(0, 15)); atb = int'($urandom_range(0, 15));
        set_a(sa, 6, ata, 1'b0);
        qa.delete();
        req_a(4'b0001, 4'h0, t);
        k1 = first_k(t, 0, 4);
        wait_k(k1 + 12);
        set_a(sb, lb, atb, 1'b0);
        req_a(4'b0001, 4'b0001, t2);
        k2 = first_k(t2, 0, 4);
        wait_k(k2 + (2 * lb + 1) * 4 + 4);
        exp_q.delete();
        model_stream(0, k1, k2 + 1, sa, 6, 0, ata, 4);
        model_stream(0, k2, k4, sb, lb, 0, atb, 4);
        collect(1'b0, 0);
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL restart_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL restart_nib%0d: got t%0d d%0h a%0h want t%0d d%0h a%0h", i,
                         got_q[i].t, got_q[i].data, got_q[i].att,
                         exp_q[i].t, exp_q[i].data, exp_q[i].att);
            end
        end
        n_chk++;
        if (bh_a[k2][0] !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got 0 want 1"); end
    endtask

    task automatic test_empty();
        int t, k1;
        set_a('h80, 0, int'($urandom_range(0, 15)), 1'b0);
        qa.delete();
        req_a(4'b1000, 4'h0, t);
        k1 = first_k(t, 3, 4);
        wait_k(k1 + 16);
        collect(1'b0, 3);
        n_chk += 3;
        if (bh_a[k1][3] !== 1'b1) begin n_fail++; $display("FAIL empty_pulse: got 0 want 1"); end
        if (bh_a[k1 + 4][3] !== 1'b0) begin n_fail++; $display("FAIL empty_end: got 1 want 0"); end
        if (got_q.size() != 0) begin
            n_fail++; $display("FAIL empty_events: got %0d want 0", got_q.size());
        end
    endtask

    task automatic test_rotation8();
        int ab[8], lb[8], atb[8], kb[8];
        int t, tp, c;
        for (int i = 0; i < 8; i++) begin
            ab[i]  = 'h400 + i * 'h100 + int'($urandom_range(0, 15));
            lb[i]  = int'($urandom_range(2, 4));
            atb[i] = int'($urandom_range(0, 15));
        end
        loop_b = 1'b0;
        qb.delete();
        req_b(8'hFF, 8'h00, t);
        for (int j = 1; j <= 8; j++) begin
            c = j % 8;
            start_addr_b = 20'(ab[c]); stop_addr_b = 20'(ab[c] + lb[c]); att_b = 4'(atb[c]);
            next_cen4();
        end
        wait_k(t + 28);
        for (int i = 0; i < 8; i++) begin
            kb[i] = first_k(t, i, 8);
            exp_q.delete();
            model_stream(i, kb[i], k4, ab[i], lb[i], 0, atb[i], 8);
            collect(1'b1, i);
            n_chk++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rot_len%0d: got %0d want %0d", i, got_q.size(), exp_q.size());
            end
            foreach (exp_q[j]) if (j < got_q.size()) begin
                n_chk++;
                if (got_q[j] !== exp_q[j]) begin
                    n_fail++;
                    $display("FAIL rot_ch%0d_nib%0d: got t%0d d%0h a%0h want t%0d d%0h a%0h", i, j,
                             got_q[j].t, got_q[j].data, got_q[j].att,
                             exp_q[j].t, exp_q[j].data, exp_q[j].att);
                end
            end
        end
        foreach (qb[i]) begin
            n_chk++;
            if (qb[i].ch != (qb[i].t - 1 - t) % 8) begin
                n_fail++; $display("FAIL rot_slot: got ch%0d want ch%0d", qb[i].ch, (qb[i].t - 1 - t) % 8);
            end
        end
        // Leave a start request pending, then reset before its slot comes round.
        req_b(8'h02, 8'h00, tp);
        rst = 1'b1;
        #1;
        n_chk += 6;
        if (busy_b !== '0)      begin n_fail++; $display("FAIL mid_rst_busy: got %0h want 0", busy_b); end
        if (pipe_en_b !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %0h want 0", pipe_en_b); end
        if (pipe_data_b !== '0) begin n_fail++; $display("FAIL mid_rst_data: got %0h want 0", pipe_data_b); end
        if (pipe_att_b !== '0)  begin n_fail++; $display("FAIL mid_rst_att: got %0h want 0", pipe_att_b); end
        if (pipe_ch_b !== '0)   begin n_fail++; $display("FAIL mid_rst_ch: got %0h want 0", pipe_ch_b); end
        if (rom_addr_b !== '0)  begin n_fail++; $display("FAIL mid_rst_addr: got %0h want 0", rom_addr_b); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        qb.delete();
        wait_k(30);
        n_chk += 2;
        if (qb.size() != 0) begin n_fail++; $display("FAIL post_rst_events: got %0d want 0", qb.size()); end
        if (busy_b !== '0) begin n_fail++; $display("FAIL post_rst_busy: got %0h want 0", busy_b); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        test_reset();
        test_oneshot();
        test_loop();
        test_stop();
        test_restart();
        test_empty();
        test_rotation8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
